diy_mole_recorder: RTL

DIY_MOLE_RECORDER -- requirements
Module: diy_mole_recorder

---
 rtl/diy_mole_recorder_pkg.sv | 26 ++
 rtl/diy_entry_ram.sv | 39 +++
 rtl/diy_mole_recorder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/diy_mole_recorder_pkg.sv
// Shared game constants for the DIY mole recorder: sizing, spacing and FSM encodings.
// Imported by the recorder top and its entry storage.
package diy_mole_recorder_pkg;

  localparam int          DIY_DEPTH   = 16;
  localparam int          DIY_ADDR_W  = 23;
  localparam logic [22:0] DIY_MIN_GAP = 23'h001000;
  localparam int          DIY_IDX_W   = 4;
  localparam int          DIY_CNT_W   = 5;
  localparam int          DIY_LOC_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RECORDING = 2'd1,
    ST_DONE      = 2'd2
  } diy_state_e;

  // Packs one stored entry as {music address, pad location}.
  function automatic logic [DIY_ADDR_W+DIY_LOC_W-1:0] pack_entry(
    input logic [DIY_ADDR_W-1:0] addr,
    input logic [DIY_LOC_W-1:0]  loc
  );
    return {addr, loc};
  endfunction

endpackage

// File: rtl/diy_entry_ram.sv
// Mole entry storage: synchronous write port and a registered read port.
// The array itself is never reset; only the read register clears on reset.
module diy_entry_ram
  import diy_mole_recorder_pkg::*;
#(
  parameter int DEPTH = DIY_DEPTH,
  parameter int WIDTH = DIY_ADDR_W + DIY_LOC_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_we,
  input  logic [DIY_IDX_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]     i_wdata,
  input  logic [DIY_IDX_W-1:0] i_raddr,
  output logic [WIDTH-1:0]     o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Write port
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/diy_mole_recorder.sv
// Records up to DEPTH timestamped pad stomps while diy_mode is high and serves
// them back by index; a stomp is kept only if it is far enough from the previous one.
module diy_mole_recorder
  import diy_mole_recorder_pkg::*;
#(
  parameter int                DEPTH   = DIY_DEPTH,
  parameter int                ADDR_W  = DIY_ADDR_W,
  parameter logic [ADDR_W-1:0] MIN_GAP = DIY_MIN_GAP
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 diy_mode,
  input  logic                 record_stop,
  input  logic                 step_valid,
  input  logic [2:0]           step_location,
  input  logic [ADDR_W-1:0]    music_address,
  input  logic [3:0]           lookup_index,
  output logic                 recording,
  output logic                 ready_to_use,
  output logic                 full,
  output logic [4:0]           total_moles,
  output logic [ADDR_W-1:0]    index_address,
  output logic [2:0]           saved_mole_location
);

  localparam logic [DIY_CNT_W-1:0] DEPTH_CNT = DIY_CNT_W'(DEPTH);

  diy_state_e              r_state;
  logic [DIY_CNT_W-1:0]    r_total;
  logic [ADDR_W-1:0]       r_last_addr;
  logic                    r_recording;
  logic                    r_ready;
  logic                    r_full;

  logic [ADDR_W:0]         w_thresh;
  logic                    w_gap_ok;
  logic                    w_accept;
  logic                    w_we;
  logic [DIY_CNT_W-1:0]    w_cnt_next;
  logic [DIY_IDX_W-1:0]    w_raddr;
  logic [ADDR_W+2:0]       w_rdata;

  // One extra bit keeps last_addr + MIN_GAP from wrapping near the top of the address space.
  assign w_thresh   = {1'b0, r_last_addr} + {1'b0, MIN_GAP};
  assign w_gap_ok   = (r_total == 5'd0) || ({1'b0, music_address} >= w_thresh);
  assign w_accept   = step_valid && !r_full && w_gap_ok;
  assign w_we       = diy_mode && (r_state == ST_RECORDING) && w_accept;
  assign w_cnt_next = r_total + {4'd0, w_we};
  assign w_raddr    = ({1'b0, lookup_index} < r_total) ? lookup_index : 4'd0;

  // Recording FSM with its counters and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_total     <= 5'd0;
      r_last_addr <= '0;
      r_recording <= 1'b0;
      r_ready     <= 1'b0;
      r_full      <= 1'b0;
    end else if (!diy_mode) begin
      r_state     <= ST_IDLE;
      r_recording <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state     <= ST_RECORDING;
          r_total     <= 5'd0;
          r_last_addr <= '0;
          r_recording <= 1'b1;
          r_ready     <= 1'b0;
          r_full      <= 1'b0;
        end
        ST_RECORDING: begin
          if (w_we) begin
            r_last_addr <= music_address;
          end else begin
            r_last_addr <= r_last_addr;
          end
          r_total <= w_cnt_next;
          r_full  <= (w_cnt_next == DEPTH_CNT);
          // The post-step count decides both auto-finish and whether record_stop counts.
          if ((w_cnt_next == DEPTH_CNT) || (record_stop && (w_cnt_next != 5'd0))) begin
            r_state     <= ST_DONE;
            r_recording <= 1'b0;
            r_ready     <= 1'b1;
          end else begin
            r_state     <= ST_RECORDING;
            r_recording <= 1'b1;
            r_ready     <= 1'b0;
          end
        end
        ST_DONE: begin
          r_state     <= ST_DONE;
          r_recording <= 1'b0;
          r_ready     <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_recording <= 1'b0;
          r_ready     <= 1'b0;
        end
      endcase
    end
  end

  diy_entry_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + 3)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (r_total[3:0]),
    .i_wdata (pack_entry(music_address, step_location)),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign recording           = r_recording;
  assign ready_to_use        = r_ready;
  assign full                = r_full;
  assign total_moles         = r_total;
  assign index_address       = w_rdata[ADDR_W+2:3];
  assign saved_mole_location = w_rdata[2:0];

endmodule
